sprite_plot_scheduler: RTL and testbench



---
 rtl/dino_game_pkg.sv | 26 ++
 rtl/sprite_pixel_walker.sv | 45 ++++
 rtl/sprite_plot_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_game_pkg.sv
// Shared definitions for the dino game: scheduler FSM encoding, screen geometry
// and palette constants.
package dino_game_pkg;

    // CLEAR is encoded as zero so the debug state reads 0 while reset is held.
    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        IDLE    = 3'd1,
        LATCH   = 3'd2,
        ERASE_D = 3'd3,
        ERASE_O = 3'd4,
        DRAW_O  = 3'd5,
        DRAW_D  = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam int DG_SCR_W    = 160;
    localparam int DG_SCR_H    = 120;
    localparam int DG_GROUND_Y = 111;

    localparam logic [2:0] DG_BG_COLOUR     = 3'b000;
    localparam logic [2:0] DG_GROUND_COLOUR = 3'b111;
    localparam logic [2:0] DG_DINO_COLOUR   = 3'b111;
    localparam logic [2:0] DG_OBS_COLOUR    = 3'b100;

endpackage

// File: rtl/sprite_pixel_walker.sv
// Walks the SPR_W x SPR_H pixels of one sprite, one per cycle, and flags pixels
// that fall off the screen. start zeroes the index; it then wraps every sprite.
module sprite_pixel_walker
    import dino_game_pkg::*;
#(
    parameter int SPR_W = 4,
    parameter int SPR_H = 4,
    parameter int SCR_W = DG_SCR_W,
    parameter int SCR_H = DG_SCR_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       in_bounds,
    output logic       last
);

    localparam int LW = $clog2(SPR_W);
    localparam int LH = $clog2(SPR_H);
    localparam int IW = LW + LH;

    logic [IW-1:0] idx;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;

    // Back-to-back phases rely on the index wrapping to 0 exactly at each boundary.
    always_ff @(posedge clk) begin
        if (!resetn || start) idx <= '0;
        else                  idx <= idx + IW'(1);
    end

    always_comb begin
        sum_x     = {1'b0, base_x} + 9'(idx[LW-1:0]);
        sum_y     = {1'b0, base_y} + 8'(idx[IW-1:LW]);
        in_bounds = (sum_x < 9'(SCR_W)) && (sum_y < 8'(SCR_H));
        last      = (idx == {IW{1'b1}});
        x         = sum_x[7:0];
        y         = sum_y[6:0];
    end

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Owns the vga_adapter pixel port: clears the screen after reset, then on each
// frame tick erases and redraws the obstacle and dino sprites.
module sprite_plot_scheduler
    import dino_game_pkg::*;
#(
    parameter int         SCR_W         = DG_SCR_W,
    parameter int         SCR_H         = DG_SCR_H,
    parameter int         SPR_W         = 4,
    parameter int         SPR_H         = 4,
    parameter int         GROUND_Y      = DG_GROUND_Y,
    parameter int         FRAME_DIV     = 833333,
    parameter logic [2:0] BG_COLOUR     = DG_BG_COLOUR,
    parameter logic [2:0] GROUND_COLOUR = DG_GROUND_COLOUR,
    parameter logic [2:0] DINO_COLOUR   = DG_DINO_COLOUR,
    parameter logic [2:0] OBS_COLOUR    = DG_OBS_COLOUR
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] dino_x,
    input  logic [6:0] dino_y,
    input  logic [7:0] obs_x,
    input  logic [6:0] obs_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       frame_done,
    output logic       busy,
    output logic       collision,
    output logic       overrun,
    output state_t     dbg_state
);

    localparam int CW = $clog2(FRAME_DIV);

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          tick, pending, take, old_valid, hit;
    logic [7:0]    cx;
    logic [6:0]    cy;
    logic [7:0]    new_dx, new_ox, old_dx, old_ox, base_x, walk_x, pix_x;
    logic [6:0]    new_dy, new_oy, old_dy, old_oy, base_y, walk_y, pix_y;
    logic [2:0]    pix_colour;
    logic          pix_plot, walk_start, walk_inb, walk_last;

    assign tick      = (tick_cnt == CW'(FRAME_DIV - 1));
    assign dbg_state = state;

    assign hit = ({1'b0, dino_x} < {1'b0, obs_x} + 9'(SPR_W)) &&
                 ({1'b0, obs_x} < {1'b0, dino_x} + 9'(SPR_W)) &&
                 ({2'b0, dino_y} < {2'b0, obs_y} + 9'(SPR_H)) &&
                 ({2'b0, obs_y} < {2'b0, dino_y} + 9'(SPR_H));

    sprite_pixel_walker #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SCR_W(SCR_W), .SCR_H(SCR_H)
    ) u_walker (
        .clk(clk), .resetn(resetn), .start(walk_start),
        .base_x(base_x), .base_y(base_y),
        .x(walk_x), .y(walk_y), .in_bounds(walk_inb), .last(walk_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= CLEAR;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        walk_start = 1'b0;
        base_x     = new_dx;
        base_y     = new_dy;
        pix_x      = walk_x;
        pix_y      = walk_y;
        pix_plot   = 1'b0;
        pix_colour = BG_COLOUR;
        case (state)
            CLEAR: begin
                pix_x      = cx;
                pix_y      = cy;
                pix_plot   = 1'b1;
                pix_colour = (cy == 7'(GROUND_Y)) ? GROUND_COLOUR : BG_COLOUR;
                if (cx == 8'(SCR_W - 1) && cy == 7'(SCR_H - 1)) state_nxt = IDLE;
            end
            IDLE: begin
                if (pending) begin
                    take      = 1'b1;
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                walk_start = 1'b1;
                state_nxt  = old_valid ? ERASE_D : DRAW_O;
            end
            ERASE_D, ERASE_O: begin
                base_x     = (state == ERASE_D) ? old_dx : old_ox;
                base_y     = (state == ERASE_D) ? old_dy : old_oy;
                pix_plot   = walk_inb;
                pix_colour = (walk_y == 7'(GROUND_Y)) ? GROUND_COLOUR : BG_COLOUR;
                if (walk_last) state_nxt = (state == ERASE_D) ? ERASE_O : DRAW_O;
            end
            DRAW_O: begin
                base_x     = new_ox;
                base_y     = new_oy;
                pix_plot   = walk_inb;
                pix_colour = OBS_COLOUR;
                if (walk_last) state_nxt = DRAW_D;
            end
            DRAW_D: begin
                pix_plot   = walk_inb;
                pix_colour = DINO_COLOUR;
                if (walk_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn || state != CLEAR) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == 8'(SCR_W - 1)) begin
            cx <= '0;
            cy <= cy + 7'd1;
        end else begin
            cx <= cx + 8'd1;
        end
    end

    // A tick landing on the same cycle IDLE consumes pending re-arms it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_cnt <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            if (take) pending <= 1'b0;
            if (tick && enable) begin
                pending <= 1'b1;
                if (pending || state != IDLE) overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            {new_dx, new_dy, new_ox, new_oy} <= '0;
            {old_dx, old_dy, old_ox, old_oy} <= '0;
            old_valid <= 1'b0;
            collision <= 1'b0;
        end else if (state == LATCH) begin
            {new_dx, new_dy, new_ox, new_oy} <= {dino_x, dino_y, obs_x, obs_y};
            collision <= hit;
        end else if (state == DONE) begin
            {old_dx, old_dy, old_ox, old_oy} <= {new_dx, new_dy, new_ox, new_oy};
            old_valid <= 1'b1;
        end
    end

    // One register stage on everything the adapter and datapaths see.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vga_x      <= pix_x;
            vga_y      <= pix_y;
            vga_colour <= pix_colour;
            vga_plot   <= pix_plot;
            frame_done <= (state == DONE);
            busy       <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Bench for sprite_plot_scheduler: a slow-tick instance for screen/sprite content
// and a fast-tick instance for overrun and back-to-back frames.
module tb_sprite_plot_scheduler;
    import dino_game_pkg::*;

    localparam int W = 18;

    logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, enable_fast = 1'b0;
    logic [7:0] dino_x = '0, obs_x = '0;
    logic [6:0] dino_y = '0, obs_y = '0;

    logic [7:0] vga_x, f_vga_x;
    logic [6:0] vga_y, f_vga_y;
    logic [2:0] vga_colour, f_vga_colour;
    logic vga_plot, frame_done, busy, collision, overrun;
    logic f_vga_plot, f_frame_done, f_busy, f_collision, f_overrun;
    state_t dbg_state, f_dbg_state;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int done_cnt = 0, f_done_cnt = 0, f_last_done = 0, f_gap = 0;
    int busy_seen = 0, f_busy_seen = 0;

    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];

    // Reference model state: last drawn positions and expected collision.
    bit m_valid = 1'b0;
    int m_dx, m_dy, m_ox, m_oy;
    bit m_col = 1'b0;

    always #5 clk = ~clk;

    sprite_plot_scheduler #(.FRAME_DIV(200)) u_dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .dino_x(dino_x), .dino_y(dino_y), .obs_x(obs_x), .obs_y(obs_y),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .frame_done(frame_done), .busy(busy), .collision(collision), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    sprite_plot_scheduler #(.FRAME_DIV(40)) u_fast (
        .clk(clk), .resetn(resetn), .enable(enable_fast),
        .dino_x(dino_x), .dino_y(dino_y), .obs_x(obs_x), .obs_y(obs_y),
        .vga_x(f_vga_x), .vga_y(f_vga_y), .vga_colour(f_vga_colour), .vga_plot(f_vga_plot),
        .frame_done(f_frame_done), .busy(f_busy), .collision(f_collision), .overrun(f_overrun),
        .dbg_state(f_dbg_state)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vga_plot) got_q.push_back({vga_x, vga_y, vga_colour});
        if (frame_done) done_cnt++;
        if (f_frame_done) begin
            f_gap = cyc - f_last_done;
            f_last_done = cyc;
            f_done_cnt++;
        end
        if (busy) busy_seen++;
        if (f_busy) f_busy_seen++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int first_diff(int base);
        int n = got_q.size() - base;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n) return i;
            if (got_q[base + i] !== exp_q[i]) return i;
        end
        if (n != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic model_sprite(int bx, int by, logic [2:0] col, bit erase);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int px = bx + c;
                int py = by + r;
                logic [2:0] pc;
                pc = erase ? ((py == 111) ? 3'd7 : 3'd0) : col;
                if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), pc});
            end
        end
    endtask

    task automatic model_frame(int dx, int dy, int ox, int oy);
        exp_q.delete();
        if (m_valid) begin
            model_sprite(m_dx, m_dy, 3'd0, 1'b1);
            model_sprite(m_ox, m_oy, 3'd0, 1'b1);
        end
        model_sprite(ox, oy, 3'b100, 1'b0);
        model_sprite(dx, dy, 3'b111, 1'b0);
        m_col = (dx < ox + 4) && (ox < dx + 4) && (dy < oy + 4) && (oy < dy + 4);
        {m_dx, m_dy, m_ox, m_oy} = {dx, dy, ox, oy};
        m_valid = 1'b1;
    endtask

    // Presents new positions, enables ticks until one frame completes, then disables.
    task automatic run_frame(input int dx, dy, ox, oy, output int base, output int frames);
        int d0 = done_cnt;
        int n = 0;
        step();
        dino_x = 8'(dx); dino_y = 7'(dy); obs_x = 8'(ox); obs_y = 7'(oy);
        base = got_q.size();
        enable = 1'b1;
        while (done_cnt == d0 && n < 1000) begin
            step();
            n++;
        end
        enable = 1'b0;
        repeat (4) step();
        frames = done_cnt - d0;
        model_frame(dx, dy, ox, oy);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({vga_x, vga_y, vga_colour, vga_plot, frame_done, busy, collision, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h required=0",
                     {vga_x, vga_y, vga_colour, vga_plot, frame_done, busy, collision, overrun});
        end
    endtask

    task automatic test_clear_restart();
        resetn = 1'b1;
        repeat (300) step();
        n_vec++;
        if ({vga_plot, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL clear_active plot,busy got=%b required=11", {vga_plot, busy});
        end
        resetn = 1'b0;
        step();
        n_vec++;
        if (vga_plot !== 1'b0) begin
            n_err++;
            $display("FAIL mid_clear_reset vga_plot got=%b required=0", vga_plot);
        end
        repeat (2) step();
    endtask

    task automatic test_clear();
        int base, n, cnt, fd;
        exp_q.delete();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back({8'(x), 7'(y), (y == 111) ? 3'd7 : 3'd0});
        base = got_q.size();
        resetn = 1'b1;
        step();
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            step();
            n++;
        end
        n_vec++;
        if (n >= 20000) begin
            n_err++;
            $display("FAIL clear_timeout busy still high after %0d cycles", n);
        end
        cnt = got_q.size() - base;
        n_vec++;
        if (cnt != 19200) begin
            n_err++;
            $display("FAIL clear_count got=%0d required=19200", cnt);
        end
        fd = first_diff(base);
        n_vec++;
        if (fd != -1) begin
            n_err++;
            $display("FAIL clear_pixels first difference at pixel %0d", fd);
        end
        if (cnt > 0) begin
            n_vec++;
            if (got_q[base] !== {8'd0, 7'd0, 3'd0}) begin
                n_err++;
                $display("FAIL clear_first got=%h required=%h", got_q[base], {8'd0, 7'd0, 3'd0});
            end
            n_vec++;
            if (got_q[base + cnt - 1] !== {8'd159, 7'd119, 3'd0}) begin
                n_err++;
                $display("FAIL clear_last got=%h required=%h", got_q[base + cnt - 1], {8'd159, 7'd119, 3'd0});
            end
        end
        n_vec++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL clear_end_state got=%0d required=%0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_first_frame();
        int base, frames, fd;
        run_frame(10, 106, 100, 106, base, frames);
        n_vec++;
        if (frames != 1) begin
            n_err++;
            $display("FAIL first_frame_done_pulses got=%0d required=1", frames);
        end
        fd = first_diff(base);
        n_vec++;
        if (fd != -1 || exp_q.size() != 32) begin
            n_err++;
            $display("FAIL first_frame_pixels diff at %0d count got=%0d required=32", fd, got_q.size() - base);
        end
        n_vec++;
        if ({collision, busy, overrun} !== 3'b000) begin
            n_err++;
            $display("FAIL first_frame_flags coll,busy,overrun got=%b required=000", {collision, busy, overrun});
        end
    endtask

    task automatic test_erase_move();
        int base, frames, fd;
        run_frame(10, 106, 99, 106, base, frames);
        fd = first_diff(base);
        n_vec++;
        if (fd != -1 || frames != 1) begin
            n_err++;
            $display("FAIL erase_move_pixels diff at %0d frames got=%0d required=1", fd, frames);
        end
        n_vec++;
        if (got_q.size() - base != 64) begin
            n_err++;
            $display("FAIL erase_move_count got=%0d required=64", got_q.size() - base);
        end
    endtask

    task automatic test_ground_erase();
        int base, frames, fd, n_gnd, n_bg, n_obs;
        run_frame(10, 108, 99, 106, base, frames);
        run_frame(10, 108, 99, 106, base, frames);
        fd = first_diff(base);
        n_vec++;
        if (fd != -1) begin
            n_err++;
            $display("FAIL ground_erase_pixels first difference at %0d", fd);
        end
        n_gnd = 0;
        n_bg = 0;
        for (int i = 0; i < 16 && base + i < got_q.size(); i++) begin
            if (got_q[base + i][9:3] == 7'd111 && got_q[base + i][2:0] == 3'd7) n_gnd++;
            if (got_q[base + i][9:3] != 7'd111 && got_q[base + i][2:0] == 3'd0) n_bg++;
        end
        n_vec++;
        if (n_gnd != 4 || n_bg != 12) begin
            n_err++;
            $display("FAIL ground_erase_colours ground got=%0d required=4 bg got=%0d required=12", n_gnd, n_bg);
        end
        run_frame(10, 108, 158, 106, base, frames);
        n_obs = 0;
        for (int i = base; i < got_q.size(); i++)
            if (got_q[i][2:0] == 3'b100) n_obs++;
        n_vec++;
        if (n_obs != 8) begin
            n_err++;
            $display("FAIL clip_obs_plots got=%0d required=8", n_obs);
        end
        fd = first_diff(base);
        n_vec++;
        if (fd != -1) begin
            n_err++;
            $display("FAIL clip_frame_pixels first difference at %0d", fd);
        end
    endtask

    task automatic test_collision();
        int base, frames;
        int pos[3][4] = '{'{10, 106, 13, 106}, '{10, 106, 14, 106}, '{10, 106, 10, 110}};
        bit req[3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            run_frame(pos[k][0], pos[k][1], pos[k][2], pos[k][3], base, frames);
            n_vec++;
            if (collision !== req[k] || m_col !== req[k]) begin
                n_err++;
                $display("FAIL collision_case%0d got=%b required=%b", k, collision, req[k]);
            end
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL slow_overrun got=%b required=0", overrun);
        end
    endtask

    task automatic test_random();
        int base, frames, fd, dx, dy, ox, oy;
        for (int k = 0; k < 8; k++) begin
            dx = $urandom_range(0, 165);
            dy = $urandom_range(0, 124);
            if (k % 2 == 1) begin
                ox = dx + $urandom_range(0, 5);
                oy = dy + $urandom_range(0, 3);
            end else begin
                ox = $urandom_range(0, 165);
                oy = $urandom_range(0, 124);
            end
            run_frame(dx, dy, ox, oy, base, frames);
            fd = first_diff(base);
            n_vec++;
            if (fd != -1 || frames != 1 || collision !== m_col) begin
                n_err++;
                $display("FAIL random_frame%0d d=(%0d,%0d) o=(%0d,%0d) diff at %0d frames=%0d coll got=%b required=%b",
                         k, dx, dy, ox, oy, fd, frames, collision, m_col);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0, d1, b0, b1, s0, n;
        d0 = f_done_cnt;
        enable_fast = 1'b1;
        n = 0;
        while (f_done_cnt < d0 + 3 && n < 3000) begin
            step();
            n++;
        end
        n_vec++;
        if (f_done_cnt < d0 + 3) begin
            n_err++;
            $display("FAIL fast_frames got=%0d required=3", f_done_cnt - d0);
        end
        n_vec++;
        if (f_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL fast_overrun got=%b required=1", f_overrun);
        end
        n_vec++;
        if (f_gap != 67) begin
            n_err++;
            $display("FAIL back_to_back_gap got=%0d required=67", f_gap);
        end
        enable_fast = 1'b0;
        repeat (300) step();
        d1 = f_done_cnt;
        b1 = f_busy_seen;
        b0 = busy_seen;
        s0 = done_cnt;
        repeat (400) step();
        n_vec++;
        if (f_done_cnt != d1 || f_busy_seen != b1) begin
            n_err++;
            $display("FAIL disabled_fast frames got=%0d busy cycles got=%0d required=0,0",
                     f_done_cnt - d1, f_busy_seen - b1);
        end
        n_vec++;
        if (done_cnt != s0 || busy_seen != b0) begin
            n_err++;
            $display("FAIL disabled_slow frames got=%0d busy cycles got=%0d required=0,0",
                     done_cnt - s0, busy_seen - b0);
        end
    endtask

    initial begin
        test_reset();
        test_clear_restart();
        test_clear();
        test_first_frame();
        test_erase_move();
        test_ground_erase();
        test_collision();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
